// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: writeback select encodings, load Fun3 codes, datapath width.
package pipeline_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // MemtoReg writeback source select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    // Load width / sign select (Fun3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/pipeline_wb_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a memory word and extends it.
// Purely combinational so the MEM stage can share it for misaligned-access checks.
module load_align
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]      fun3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane extraction followed by sign/zero extension; unknown Fun3 passes the word through
    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = word_i[{off_i[1], 4'b0000} +: 16];
        data_o = word_i;
        case (fun3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/pipeline_wb.sv
// MEM/WB pipeline register and writeback stage of the RV32I pipeline.
// Drives the register-file write port, the hazard-unit forwarding valid and a retire strobe.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter (Retire_cnt_WB).
module pipeline_wb
    import pipeline_pkg::*;
#(
    parameter int unsigned     XLEN   = XLEN_DEF,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk_WB,
    input  logic            rst_WB,
    input  logic            stall_WB,
    input  logic            flush_WB,
    input  logic            valid_in_WB,
    input  logic [XLEN-1:0] PC_in_WB,
    input  logic [XLEN-1:0] ALU_out_in_WB,
    input  logic [XLEN-1:0] Mem_data_in_WB,
    input  logic [XLEN-1:0] Imm_in_WB,
    input  logic [2:0]      Fun3_in_WB,
    input  logic [1:0]      MemtoReg_in_WB,
    input  logic            RegWrite_in_WB,
    input  logic [4:0]      Rd_addr_in_WB,
    output logic [4:0]      Rd_addr_WB,
    output logic [XLEN-1:0] Wt_data_WB,
    output logic            RegWrite_WB,
    output logic            Fwd_valid_WB,
    output logic            Retire_WB
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     Retire_cnt_WB
`endif
);

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] alu_q,      alu_d;
    logic [XLEN-1:0] mem_q,      mem_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [2:0]      fun3_q,     fun3_d;
    logic [1:0]      sel_q,      sel_d;
    logic            rw_q,       rw_d;
    logic [4:0]      rd_q,       rd_d;
    logic            retired_q,  retired_d;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_sel_data;
    logic            first_cycle;
    logic            we;

    // Next-state for the MEM/WB register: flush > stall > normal load (reset handled in the flop)
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        mem_d     = mem_q;
        imm_d     = imm_q;
        fun3_d    = fun3_q;
        sel_d     = sel_q;
        rw_d      = rw_q;
        rd_d      = rd_q;
        retired_d = retired_q;
        if (flush_WB) begin
            valid_d   = 1'b0;
            rw_d      = 1'b0;
            rd_d      = 5'd0;
            pc_d      = RST_PC;
            retired_d = 1'b0;
        end else if (stall_WB) begin
            // a held valid instruction has already retired after its first cycle
            retired_d = retired_q | valid_q;
        end else begin
            valid_d   = valid_in_WB;
            pc_d      = PC_in_WB;
            alu_d     = ALU_out_in_WB;
            mem_d     = Mem_data_in_WB;
            imm_d     = Imm_in_WB;
            fun3_d    = Fun3_in_WB;
            sel_d     = MemtoReg_in_WB;
            rw_d      = valid_in_WB & RegWrite_in_WB;
            rd_d      = Rd_addr_in_WB;
            retired_d = 1'b0;
        end
    end

    // MEM/WB register with synchronous reset
    always_ff @(posedge clk_WB) begin
        if (rst_WB) begin
            valid_q   <= 1'b0;
            pc_q      <= RST_PC;
            alu_q     <= '0;
            mem_q     <= '0;
            imm_q     <= '0;
            fun3_q    <= 3'd0;
            sel_q     <= 2'd0;
            rw_q      <= 1'b0;
            rd_q      <= 5'd0;
            retired_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            imm_q     <= imm_d;
            fun3_q    <= fun3_d;
            sel_q     <= sel_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            retired_q <= retired_d;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .fun3_i (fun3_q),
        .off_i  (alu_q[1:0]),
        .word_i (mem_q),
        .data_o (load_data)
    );

    // Writeback mux and write-port qualification; a reset in progress discards the instruction
    always_comb begin
        first_cycle = valid_q & ~retired_q & ~rst_WB;
        we          = first_cycle & rw_q & (rd_q != 5'd0);
        wb_sel_data = alu_q;
        case (sel_q)
            WB_SEL_ALU: wb_sel_data = alu_q;
            WB_SEL_MEM: wb_sel_data = load_data;
            WB_SEL_PC4: wb_sel_data = pc_q + XLEN'(4);
            WB_SEL_IMM: wb_sel_data = imm_q;
            default:    wb_sel_data = alu_q;
        endcase
        RegWrite_WB  = we;
        Fwd_valid_WB = we;
        Rd_addr_WB   = we ? rd_q : 5'd0;
        Wt_data_WB   = we ? wb_sel_data : '0;
        Retire_WB    = first_cycle;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    // Retired-instruction count; wraps naturally, only reset clears it
    always_comb begin
        cnt_d = cnt_q;
        if (Retire_WB) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_WB) begin
        if (rst_WB) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Retire_cnt_WB = cnt_q;
`endif

endmodule
